// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame sequencer.
// Frame on the wire: SYNC, OPCODE, ARG_HI, ARG_LO, CHK (XOR of the middle three bytes).
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPC    = 3'd1,
    ARG_HI = 3'd2,
    ARG_LO = 3'd3,
    CHK    = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_BYTES   = 5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: counts clocks since the last byte while a frame is open.
// o_expire is high for one cycle, on the cycle the count reaches TIMEOUT_CLKS-1 with no byte present.
module uart_frame_timeout #(
  parameter int TIMEOUT_CLKS = 10400,
  localparam int TW = $clog2(TIMEOUT_CLKS)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] r_timer;

  // A byte arriving on the expiry cycle suppresses the expiry.
  assign o_expire = i_en & ~i_clear & (r_timer == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (!i_en || i_clear || o_expire) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles uart_rx bytes into 5-byte command frames, checks the XOR checksum,
// enforces the inter-byte timeout and reports good/errored frames.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = 10400,
  parameter int         CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             cmd_valid,
  output logic [7:0]       cmd_opcode,
  output logic [15:0]      cmd_arg,
  output logic             err_chk,
  output logic             err_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       dbg_state
);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_opc;
  logic [7:0]       r_arg_hi;
  logic [7:0]       r_arg_lo;
  logic [7:0]       r_chk_acc;
  logic             r_cmd_valid;
  logic [7:0]       r_cmd_opcode;
  logic [15:0]      r_cmd_arg;
  logic             r_err_chk;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_busy;
  logic             w_expire;
  logic             w_chk_ok;
  logic             w_chk_bad;

  assign w_busy = (r_state != IDLE);

  uart_frame_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_busy),
    .i_clear (rx_valid),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // SYNC is only special in IDLE; inside a frame it is ordinary payload.
  always_comb begin
    w_state_next = r_state;
    if (w_expire) begin
      w_state_next = IDLE;
    end else if (rx_valid) begin
      case (r_state)
        IDLE:    if (rx_data == SYNC_BYTE) w_state_next = OPC;
        OPC:     w_state_next = ARG_HI;
        ARG_HI:  w_state_next = ARG_LO;
        ARG_LO:  w_state_next = CHK;
        CHK:     w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_chk_ok  = 1'b0;
    w_chk_bad = 1'b0;
    if (r_state == CHK && rx_valid) begin
      if (rx_data == r_chk_acc) w_chk_ok  = 1'b1;
      else                      w_chk_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opc     <= '0;
      r_arg_hi  <= '0;
      r_arg_lo  <= '0;
      r_chk_acc <= '0;
    end else if (w_expire) begin
      r_opc     <= '0;
      r_arg_hi  <= '0;
      r_arg_lo  <= '0;
      r_chk_acc <= '0;
    end else if (rx_valid) begin
      case (r_state)
        OPC: begin
          r_opc     <= rx_data;
          r_chk_acc <= rx_data;
        end
        ARG_HI: begin
          r_arg_hi  <= rx_data;
          r_chk_acc <= r_chk_acc ^ rx_data;
        end
        ARG_LO: begin
          r_arg_lo  <= rx_data;
          r_chk_acc <= r_chk_acc ^ rx_data;
        end
        default: ;
      endcase
    end
  end

  // Decoded fields only move together with the cmd_valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_valid   <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_cmd_opcode  <= '0;
      r_cmd_arg     <= '0;
      r_good_cnt    <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_cmd_valid   <= w_chk_ok;
      r_err_chk     <= w_chk_bad;
      r_err_timeout <= w_expire;
      if (w_chk_ok) begin
        r_cmd_opcode <= r_opc;
        r_cmd_arg    <= {r_arg_hi, r_arg_lo};
        r_good_cnt   <= r_good_cnt + CNT_W'(1);
      end
      if (w_chk_bad || w_expire) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_opcode  = r_cmd_opcode;
  assign cmd_arg     = r_cmd_arg;
  assign err_chk     = r_err_chk;
  assign err_timeout = r_err_timeout;
  assign busy        = w_busy;
  assign good_cnt    = r_good_cnt;
  assign err_cnt     = r_err_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed frames plus random traffic, checked every
// cycle against a frame-level model built from a byte queue and byte timestamps.
module tb_uart_frame_ctrl;

  localparam int         TO   = 64;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_arg;
  logic        err_chk;
  logic        err_timeout;
  logic        busy;
  logic [7:0]  good_cnt;
  logic [7:0]  err_cnt;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int cmd_cyc = 0;
  int to_cyc = 0;
  int n_cmd = 0;
  int n_echk = 0;
  int n_eto = 0;
  logic busy_at_to = 1'b1;

  // Model state
  logic [7:0]  frame_q[$];
  int          m_last = 0;
  logic        exp_cmd_valid = 1'b0;
  logic        exp_err_chk = 1'b0;
  logic        exp_err_to = 1'b0;
  logic [7:0]  exp_opc = 8'h00;
  logic [15:0] exp_arg = 16'h0000;
  logic [7:0]  exp_good = 8'h00;
  logic [7:0]  exp_err = 8'h00;
  logic        exp_busy = 1'b0;

  uart_frame_ctrl #(
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(TO),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_opcode (cmd_opcode),
    .cmd_arg    (cmd_arg),
    .err_chk    (err_chk),
    .err_timeout(err_timeout),
    .busy       (busy),
    .good_cnt   (good_cnt),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is the list of bytes taken since SYNC; it
  // expires when TO clocks pass after its last byte with no new byte.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q.delete();
      exp_cmd_valid = 1'b0;
      exp_err_chk   = 1'b0;
      exp_err_to    = 1'b0;
      exp_opc       = 8'h00;
      exp_arg       = 16'h0000;
      exp_good      = 8'h00;
      exp_err       = 8'h00;
      exp_busy      = 1'b0;
    end else begin
      exp_cmd_valid = 1'b0;
      exp_err_chk   = 1'b0;
      exp_err_to    = 1'b0;
      if (frame_q.size() > 0 && !rx_valid && (cyc - m_last) == TO) begin
        exp_err_to = 1'b1;
        exp_err    = exp_err + 8'd1;
        frame_q.delete();
      end else if (rx_valid) begin
        m_last = cyc;
        if (frame_q.size() == 0) begin
          if (rx_data == SYNC) frame_q.push_back(rx_data);
        end else begin
          frame_q.push_back(rx_data);
          if (frame_q.size() == 5) begin
            if ((frame_q[1] ^ frame_q[2] ^ frame_q[3]) == frame_q[4]) begin
              exp_cmd_valid = 1'b1;
              exp_opc       = frame_q[1];
              exp_arg       = {frame_q[2], frame_q[3]};
              exp_good      = exp_good + 8'd1;
            end else begin
              exp_err_chk = 1'b1;
              exp_err     = exp_err + 8'd1;
            end
            frame_q.delete();
          end
        end
      end
      exp_busy = (frame_q.size() != 0);
    end
  end

  // Compare process: every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      check("cmd_valid",   cmd_valid,   exp_cmd_valid);
      check("err_chk",     err_chk,     exp_err_chk);
      check("err_timeout", err_timeout, exp_err_to);
      check("busy",        busy,        exp_busy);
      check("cmd_opcode",  cmd_opcode,  exp_opc);
      check("cmd_arg",     cmd_arg,     exp_arg);
      check("good_cnt",    good_cnt,    exp_good);
      check("err_cnt",     err_cnt,     exp_err);
      if (cmd_valid) begin
        n_cmd++;
        cmd_cyc = cyc;
      end
      if (err_chk) n_echk++;
      if (err_timeout) begin
        n_eto++;
        to_cyc = cyc;
        busy_at_to = busy;
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the falling edge
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  // gap = clocks between the previous byte's sampling edge and this one
  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap - 1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    #1;
    last_strobe_cyc = cyc;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] chk, input int gmin, input int gmax);
    send_byte(SYNC, $urandom_range(gmax, gmin));
    send_byte(opc,  $urandom_range(gmax, gmin));
    send_byte(hi,   $urandom_range(gmax, gmin));
    send_byte(lo,   $urandom_range(gmax, gmin));
    send_byte(chk,  $urandom_range(gmax, gmin));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cmd_valid"},   cmd_valid,   0);
    check({tag, "_cmd_opcode"},  cmd_opcode,  0);
    check({tag, "_cmd_arg"},     cmd_arg,     0);
    check({tag, "_err_chk"},     err_chk,     0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_good_cnt"},    good_cnt,    0);
    check({tag, "_err_cnt"},     err_cnt,     0);
    check({tag, "_state"},       dbg_state,   0);
  endtask

  initial begin
    int s_cmd;
    int s_echk;
    int s_eto;
    int t0;
    logic [7:0] o, h, l, c;

    // Reset
    #1 rst = 1'b1;
    #2;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    idle(3);

    // Good frame A5 01 12 34 27
    s_cmd = n_cmd;
    send_frame(8'h01, 8'h12, 8'h34, 8'h27, 20, 20);
    check("f1_latency", cmd_cyc, last_strobe_cyc);
    check("f1_pulses", n_cmd - s_cmd, 1);
    check("f1_opcode", cmd_opcode, 8'h01);
    check("f1_arg", cmd_arg, 16'h1234);
    check("f1_good_cnt", good_cnt, 1);
    check("f1_err_cnt", err_cnt, 0);
    idle(4);

    // Bad checksum A5 01 12 34 28
    s_cmd = n_cmd; s_echk = n_echk;
    send_frame(8'h01, 8'h12, 8'h34, 8'h28, 20, 20);
    idle(4);
    check("f2_err_chk_pulses", n_echk - s_echk, 1);
    check("f2_cmd_pulses", n_cmd - s_cmd, 0);
    check("f2_opcode_held", cmd_opcode, 8'h01);
    check("f2_arg_held", cmd_arg, 16'h1234);
    check("f2_err_cnt", err_cnt, 1);

    // Garbage before SYNC is ignored
    send_byte(8'h00, 5);
    check("f3_busy_after_00", busy, 0);
    send_byte(8'hFF, 5);
    check("f3_busy_after_ff", busy, 0);
    send_frame(8'h10, 8'h00, 8'h00, 8'h10, 5, 5);
    check("f3_opcode", cmd_opcode, 8'h10);
    check("f3_arg", cmd_arg, 16'h0000);
    check("f3_good_cnt", good_cnt, 2);
    idle(4);

    // Timeout after A5 01, then a good frame
    s_eto = n_eto;
    send_byte(SYNC, 3);
    send_byte(8'h01, 3);
    t0 = last_strobe_cyc;
    idle(TO + 5);
    check("to_pulses", n_eto - s_eto, 1);
    check("to_latency", to_cyc - t0, TO);
    check("to_busy_drop", busy_at_to, 0);
    check("to_err_cnt", err_cnt, 2);
    send_frame(8'h02, 8'hAB, 8'hCD, 8'h64, 3, 10);
    check("to_next_opcode", cmd_opcode, 8'h02);
    check("to_next_arg", cmd_arg, 16'hABCD);
    check("to_next_good_cnt", good_cnt, 3);
    idle(4);

    // Byte lands exactly on the expiry cycle
    s_eto = n_eto; s_cmd = n_cmd;
    send_byte(SYNC, 3);
    send_byte(8'h5C, 5);
    send_byte(8'h12, TO);
    send_byte(8'h34, TO);
    send_byte(8'h7A, TO);
    check("exp_no_timeout", n_eto - s_eto, 0);
    check("exp_cmd_pulse", n_cmd - s_cmd, 1);
    check("exp_opcode", cmd_opcode, 8'h5C);
    check("exp_arg", cmd_arg, 16'h1234);
    idle(4);

    // Reset mid-frame
    s_cmd = n_cmd; s_echk = n_echk; s_eto = n_eto;
    send_byte(SYNC, 2);
    send_byte(8'h01, 2);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    #1 rst = 1'b0;
    idle(TO + 4);
    check("midrst_no_strobes", (n_cmd - s_cmd) + (n_echk - s_echk) + (n_eto - s_eto), 0);
    send_byte(8'h12, 2);
    check("midrst_needs_sync", busy, 0);

    // Back-to-back frames, then wrap of good_cnt at 256
    send_frame(8'h33, 8'h44, 8'h55, 8'h33 ^ 8'h44 ^ 8'h55, 1, 1);
    send_frame(8'h66, 8'h77, 8'h88, 8'h66 ^ 8'h77 ^ 8'h88, 1, 1);
    check("b2b_good_cnt", good_cnt, 2);
    check("b2b_opcode", cmd_opcode, 8'h66);
    for (int i = 0; i < 254; i++) begin
      o = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
      send_frame(o, h, l, o ^ h ^ l, 1, 4);
      if (i == 252) check("wrap_255", good_cnt, 8'd255);
    end
    check("wrap_0", good_cnt, 0);
    check("wrap_err_cnt", err_cnt, 0);
    idle(3);

    // Random mix: good, bad checksum, timeout, idle garbage
    for (int i = 0; i < 80; i++) begin
      int mode;
      mode = $urandom_range(3, 0);
      o = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
      case (mode)
        0: send_frame(o, h, l, o ^ h ^ l, 1, TO);
        1: send_frame(o, h, l, (o ^ h ^ l) ^ 8'($urandom_range(255, 1)), 1, TO);
        2: begin
          send_byte(SYNC, $urandom_range(8, 1));
          for (int k = 0; k < int'($urandom_range(3, 0)); k++) send_byte(8'($urandom), $urandom_range(TO, 1));
          idle(TO + $urandom_range(4, 1));
        end
        default: begin
          c = 8'($urandom);
          if (c == SYNC) c = 8'h00;
          send_byte(c, $urandom_range(8, 1));
        end
      endcase
    end
    idle(TO + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Sequences the byte stream from the UART receiver into fixed 5-byte command frames.
- Frame format: SYNC (0xA5), OPCODE, ARG_HI, ARG_LO, CHK.
- Validates the XOR checksum and enforces an inter-byte timeout.
- Emits a one-cycle command strobe with decoded fields to downstream register/LED logic.
- Sits between uart_rx (data_out/data_valid) and the board-level command consumers on the 12 MHz clock domain.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 10400, max clocks between consecutive bytes inside a frame (10 byte times at 115200 baud, 12 MHz). Must be ≥2.
- CNT_W, 8, width of the good/error frame counters.

Ports:
- clk  in  1  system clock (12 MHz)
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  byte from uart_rx data_out
- rx_valid  in  1  one-cycle strobe from uart_rx data_valid
- cmd_valid  out  1  one-cycle strobe: good frame decoded
- cmd_opcode  out  8  opcode of last good frame
- cmd_arg  out  16  {ARG_HI, ARG_LO} of last good frame
- err_chk  out  1  one-cycle strobe: checksum mismatch
- err_timeout  out  1  one-cycle strobe: inter-byte timeout mid-frame
- busy  out  1  high while state != IDLE
- good_cnt  out  CNT_W  good frames received, wraps
- err_cnt  out  CNT_W  errored frames (chk + timeout), wraps

Behaviour:
- Reset (async assert, clk-synchronous deassert use) puts every output and internal register to 0: state=IDLE, timer=0, cmd_* = 0, strobes 0, counters 0.
- FSM states and transitions:
  - IDLE: on rx_valid with rx_data==SYNC_BYTE → OPC. Any other byte is ignored silently (no error, no count).
  - OPC: on rx_valid, capture opcode and set chk_acc=rx_data → ARG_HI.
  - ARG_HI: on rx_valid, capture, chk_acc^=rx_data → ARG_LO.
  - ARG_LO: on rx_valid, capture, chk_acc^=rx_data → CHK.
  - CHK: on rx_valid → IDLE.
    - If rx_data==chk_acc: update cmd_opcode/cmd_arg and pulse cmd_valid; good_cnt+1.
    - Otherwise: pulse err_chk; err_cnt+1; cmd_opcode/cmd_arg hold their previous values.
- SYNC_BYTE received inside a frame is ordinary data; there is no resync.
- Latency: cmd_valid/err_chk are registered and assert exactly 1 clk after the rx_valid cycle carrying CHK. All strobes are 1 cycle wide.
- cmd_opcode/cmd_arg change only in the same cycle cmd_valid asserts, and are stable otherwise.
- Timeout:
  - timer clears on every rx_valid and is held at 0 in IDLE.
  - Otherwise timer increments each clk.
  - When timer == TIMEOUT_CLKS-1 and rx_valid is low, the next cycle: state=IDLE, err_timeout=1, err_cnt+1, captured fields discarded.
  - If rx_valid arrives in the expiry cycle, the byte wins and no timeout fires.
- Counters wrap modulo 2^CNT_W; no saturation.
- err_chk and err_timeout are mutually exclusive by construction. cmd_valid never coincides with either.
- busy = (state != IDLE), combinational from the state register.
- rst asserted mid-frame aborts immediately with no error strobe. The next frame must start with SYNC.
- Back-to-back frames: SYNC may arrive in the cycle right after the CHK byte; IDLE accepts it.

Decomposition:
- Package uart_frame_pkg:
  - state enum (IDLE, OPC, ARG_HI, ARG_LO, CHK), 3-bit encoding.
  - Default SYNC_BYTE constant.
  - Frame length constant FRAME_BYTES=5.
- Natural sub-module: uart_frame_timeout. Parameterised down-counter/up-counter with clear, enable (=busy) and one-cycle expire output; width $clog2(TIMEOUT_CLKS).
- FSM, checksum accumulator and counters stay in uart_frame_ctrl.

Test Plan:
- Bytes A5,01,12,34,27 (one every 1040 clk) → cmd_valid 1 clk after last strobe, cmd_opcode=01, cmd_arg=1234, good_cnt=1, err_cnt=0.
- Bytes A5,01,12,34,28 → err_chk one pulse, cmd_valid never, cmd_opcode/cmd_arg unchanged, err_cnt=1.
- Bytes 00,FF,A5,10,00,00,10 → leading 00,FF ignored (busy stays 0), then cmd_valid with opcode=10, arg=0000.
- A5,01 then silence → err_timeout exactly TIMEOUT_CLKS clk after the 01 strobe. busy drops the same cycle. A following full good frame decodes correctly.
- rx_valid landing exactly in the timer-expiry cycle → no err_timeout, frame continues. Then rst pulsed mid-frame → all outputs 0, no strobes.
- Two good frames back-to-back with SYNC in the cycle after CHK, then 256 good frames total → good_cnt wraps to 0.
